multicycle_control: RTL and testbench

- Sequential successor to the single-cycle central/ALU controller: a multi-cycle MIPS-subset control FSM.
- Sequences each instruction through FETCH, DECODE, EXEC, MEM and WB, using one shared memory port with a req/ready handshake.
- Keeps the single-cycle datapath encodings for in1_mux, in2_mux, alu_op, reg_dst, mem_to_reg and jump.
- Adds PC/IR write enables, memory wait states, and a cycle-accurate completion pulse.

---
 rtl/multicycle_pkg.sv | 86 ++++++++
 rtl/multicycle_control_alu_decode.sv | 53 +++++
 rtl/multicycle_control.sv | 190 +++++++++++++++++++
 tb/tb_multicycle_control.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/multicycle_pkg.sv
// rtl/multicycle_pkg.sv - shared states, opcode/func constants, ALU and mux encodings
package multicycle_pkg;

   typedef enum logic [2:0] {
      FETCH  = 3'd0,
      DECODE = 3'd1,
      EXEC   = 3'd2,
      MEM    = 3'd3,
      WB     = 3'd4,
      TRAP   = 3'd5
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_SLTIU = 6'h0B;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_XORI  = 6'h0E;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_SLL  = 6'h00;
   localparam logic [5:0] FN_SRL  = 6'h02;
   localparam logic [5:0] FN_SRA  = 6'h03;
   localparam logic [5:0] FN_SLLV = 6'h04;
   localparam logic [5:0] FN_SRLV = 6'h06;
   localparam logic [5:0] FN_SRAV = 6'h07;
   localparam logic [5:0] FN_JR   = 6'h08;
   localparam logic [5:0] FN_ADD  = 6'h20;
   localparam logic [5:0] FN_ADDU = 6'h21;
   localparam logic [5:0] FN_SUB  = 6'h22;
   localparam logic [5:0] FN_SUBU = 6'h23;
   localparam logic [5:0] FN_AND  = 6'h24;
   localparam logic [5:0] FN_OR   = 6'h25;
   localparam logic [5:0] FN_XOR  = 6'h26;
   localparam logic [5:0] FN_NOR  = 6'h27;
   localparam logic [5:0] FN_SLT  = 6'h2A;
   localparam logic [5:0] FN_SLTU = 6'h2B;

   // addu/subu share add/sub: the ALU does not distinguish overflow behaviour
   localparam logic [3:0] ALU_SLL  = 4'd0;
   localparam logic [3:0] ALU_SRL  = 4'd1;
   localparam logic [3:0] ALU_SRA  = 4'd2;
   localparam logic [3:0] ALU_SLLV = 4'd3;
   localparam logic [3:0] ALU_SRLV = 4'd4;
   localparam logic [3:0] ALU_SRAV = 4'd5;
   localparam logic [3:0] ALU_ADD  = 4'd6;
   localparam logic [3:0] ALU_SUB  = 4'd7;
   localparam logic [3:0] ALU_AND  = 4'd8;
   localparam logic [3:0] ALU_OR   = 4'd9;
   localparam logic [3:0] ALU_XOR  = 4'd10;
   localparam logic [3:0] ALU_NOR  = 4'd11;
   localparam logic [3:0] ALU_SLT  = 4'd12;
   localparam logic [3:0] ALU_SLTU = 4'd13;
   localparam logic [3:0] ALU_LUI  = 4'd14;

   localparam logic [1:0] IN1_RT    = 2'd0;
   localparam logic [1:0] IN1_SEXT  = 2'd1;
   localparam logic [1:0] IN1_ZEXT  = 2'd2;
   localparam logic       IN2_RS    = 1'b0;
   localparam logic       IN2_SHAMT = 1'b1;

   localparam logic [1:0] PC_SEQ  = 2'd0;
   localparam logic [1:0] PC_BR   = 2'd1;
   localparam logic [1:0] PC_JUMP = 2'd2;
   localparam logic [1:0] PC_REG  = 2'd3;

   localparam logic [1:0] DST_RT = 2'd0;
   localparam logic [1:0] DST_RD = 2'd1;
   localparam logic [1:0] DST_RA = 2'd2;

   localparam logic [1:0] M2R_ALU = 2'd0;
   localparam logic [1:0] M2R_MDR = 2'd1;
   localparam logic [1:0] M2R_PC4 = 2'd2;

   function automatic logic is_jr(input logic [5:0] opcode, input logic [5:0] func);
      return (opcode == OP_RTYPE) && (func == FN_JR);
   endfunction

endpackage

// File: rtl/multicycle_control_alu_decode.sv
// rtl/multicycle_control_alu_decode.sv - combinational opcode/func to ALU operand and function decoder
module alu_decode
   import multicycle_pkg::*;
(
   input  logic [5:0] opcode,
   input  logic [5:0] func,
   output logic [1:0] in1_mux,
   output logic       in2_mux,
   output logic [3:0] alu_op,
   output logic       legal
);

   always_comb begin
      in1_mux = IN1_RT;
      in2_mux = IN2_RS;
      alu_op  = ALU_SLL;
      legal   = 1'b1;
      case (opcode)
         OP_RTYPE: begin
            case (func)
               FN_SLL:          begin in2_mux = IN2_SHAMT; alu_op = ALU_SLL; end
               FN_SRL:          begin in2_mux = IN2_SHAMT; alu_op = ALU_SRL; end
               FN_SRA:          begin in2_mux = IN2_SHAMT; alu_op = ALU_SRA; end
               FN_SLLV:         alu_op = ALU_SLLV;
               FN_SRLV:         alu_op = ALU_SRLV;
               FN_SRAV:         alu_op = ALU_SRAV;
               FN_JR:           ;
               FN_ADD, FN_ADDU: alu_op = ALU_ADD;
               FN_SUB, FN_SUBU: alu_op = ALU_SUB;
               FN_AND:          alu_op = ALU_AND;
               FN_OR:           alu_op = ALU_OR;
               FN_XOR:          alu_op = ALU_XOR;
               FN_NOR:          alu_op = ALU_NOR;
               FN_SLT:          alu_op = ALU_SLT;
               FN_SLTU:         alu_op = ALU_SLTU;
               default:         legal = 1'b0;
            endcase
         end
         OP_J, OP_JAL:   ;
         OP_BEQ, OP_BNE: alu_op = ALU_SUB;
         OP_ADDI:        begin in1_mux = IN1_SEXT; alu_op = ALU_ADD;  end
         OP_SLTI:        begin in1_mux = IN1_SEXT; alu_op = ALU_SLT;  end
         OP_SLTIU:       begin in1_mux = IN1_SEXT; alu_op = ALU_SLTU; end
         OP_ANDI:        begin in1_mux = IN1_ZEXT; alu_op = ALU_AND;  end
         OP_ORI:         begin in1_mux = IN1_ZEXT; alu_op = ALU_OR;   end
         OP_XORI:        begin in1_mux = IN1_ZEXT; alu_op = ALU_XOR;  end
         OP_LUI:         begin in1_mux = IN1_ZEXT; alu_op = ALU_LUI;  end
         OP_LW, OP_SW:   begin in1_mux = IN1_SEXT; alu_op = ALU_ADD;  end
         default:        legal = 1'b0;
      endcase
   end

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multi-cycle MIPS-subset control FSM; MULTICYCLE_TRAP_EN adds TRAP state and wait timeout
module multicycle_control
   import multicycle_pkg::*;
#(
   parameter int ALU_OP_W = 4,
   parameter int WAIT_MAX = 16,
   parameter int STATE_W  = 3
)(
   input  logic                clk,
   input  logic                rst_n,
   input  logic [5:0]          opcode,
   input  logic [5:0]          func,
   input  logic                zero,
   input  logic                mem_ready,
   output logic                mem_req,
   output logic                mem_we,
   output logic                ir_write,
   output logic                pc_write,
   output logic [1:0]          pc_src,
   output logic [1:0]          in1_mux,
   output logic                in2_mux,
   output logic [ALU_OP_W-1:0] alu_op,
   output logic [1:0]          reg_dst,
   output logic [1:0]          mem_to_reg,
   output logic                reg_write,
   output logic                instr_done,
   output logic [STATE_W-1:0]  state_o
`ifdef MULTICYCLE_TRAP_EN
   ,
   output logic                trap
`endif
);

   state_t     state, next;
   logic [1:0] dec_in1;
   logic       dec_in2;
   logic [3:0] dec_op;
   logic       legal;
   logic [3:0] op_sel;

   alu_decode u_dec (
      .opcode  (opcode),
      .func    (func),
      .in1_mux (dec_in1),
      .in2_mux (dec_in2),
      .alu_op  (dec_op),
      .legal   (legal)
   );

`ifdef MULTICYCLE_TRAP_EN
   localparam int WAIT_CNT_W = $clog2(WAIT_MAX + 1);
   logic [WAIT_CNT_W-1:0] wait_cnt;
   logic                  waiting;

   assign waiting = ((state == FETCH) || (state == MEM)) && !mem_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       wait_cnt <= '0;
      else if (waiting) wait_cnt <= wait_cnt + 1'b1;
      else              wait_cnt <= '0;
   end

   assign trap = (state == TRAP);
`else
   logic unused_wait_max;
   assign unused_wait_max = (WAIT_MAX != 0);
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= FETCH;
      else        state <= next;
   end

   // Outputs are gated by rst_n so an abandoned access drops mem_req without waiting for an edge
   always_comb begin
      next       = state;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      pc_src     = PC_SEQ;
      in1_mux    = IN1_RT;
      in2_mux    = IN2_RS;
      op_sel     = ALU_SLL;
      reg_dst    = DST_RT;
      mem_to_reg = M2R_ALU;
      reg_write  = 1'b0;
      instr_done = 1'b0;
      if (rst_n) begin
         case (state)
            FETCH: begin
               mem_req = 1'b1;
               if (mem_ready) begin
                  ir_write = 1'b1;
                  pc_write = 1'b1;
                  next     = DECODE;
               end
            end
            DECODE: begin
               if (opcode == OP_J) begin
                  pc_write   = 1'b1;
                  pc_src     = PC_JUMP;
                  instr_done = 1'b1;
                  next       = FETCH;
               end else if (is_jr(opcode, func)) begin
                  pc_write   = 1'b1;
                  pc_src     = PC_REG;
                  instr_done = 1'b1;
                  next       = FETCH;
               end else if (opcode == OP_JAL) begin
                  pc_write = 1'b1;
                  pc_src   = PC_JUMP;
                  next     = WB;
`ifdef MULTICYCLE_TRAP_EN
               end else if (!legal) begin
                  next = TRAP;
`endif
               end else begin
                  next = EXEC;
               end
            end
            EXEC: begin
               in1_mux = dec_in1;
               in2_mux = dec_in2;
               op_sel  = dec_op;
               if (!legal) begin
                  instr_done = 1'b1;
                  next       = FETCH;
               end else begin
                  case (opcode)
                     OP_LW, OP_SW: next = MEM;
                     OP_BEQ: begin
                        pc_write   = zero;
                        pc_src     = PC_BR;
                        instr_done = 1'b1;
                        next       = FETCH;
                     end
                     OP_BNE: begin
                        pc_write   = ~zero;
                        pc_src     = PC_BR;
                        instr_done = 1'b1;
                        next       = FETCH;
                     end
                     default: next = WB;
                  endcase
               end
            end
            MEM: begin
               mem_req = 1'b1;
               mem_we  = (opcode == OP_SW);
               in1_mux = IN1_SEXT;
               op_sel  = ALU_ADD;
               if (mem_ready) begin
                  if (opcode == OP_SW) begin
                     instr_done = 1'b1;
                     next       = FETCH;
                  end else begin
                     next = WB;
                  end
               end
            end
            WB: begin
               reg_write  = 1'b1;
               instr_done = 1'b1;
               next       = FETCH;
               case (opcode)
                  OP_RTYPE: reg_dst = DST_RD;
                  OP_LW:    mem_to_reg = M2R_MDR;
                  OP_JAL: begin
                     reg_dst    = DST_RA;
                     mem_to_reg = M2R_PC4;
                  end
                  default: ;
               endcase
            end
`ifdef MULTICYCLE_TRAP_EN
            TRAP: next = TRAP;
`endif
            default: next = FETCH;
         endcase
`ifdef MULTICYCLE_TRAP_EN
         if (waiting && (wait_cnt == WAIT_CNT_W'(WAIT_MAX - 1))) next = TRAP;
`endif
      end
   end

   assign alu_op  = ALU_OP_W'(op_sel);
   assign state_o = STATE_W'(state);

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - directed self-checking bench for multicycle_control
module tb_multicycle_control;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [5:0] opcode, func;
   logic       zero, mem_ready;
   logic       mem_req, mem_we, ir_write, pc_write, in2_mux, reg_write, instr_done;
   logic [1:0] pc_src, in1_mux, reg_dst, mem_to_reg;
   logic [3:0] alu_op;
   logic [2:0] state_o;
`ifdef MULTICYCLE_TRAP_EN
   logic       trap;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   multicycle_control dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .opcode     (opcode),
      .func       (func),
      .zero       (zero),
      .mem_ready  (mem_ready),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .ir_write   (ir_write),
      .pc_write   (pc_write),
      .pc_src     (pc_src),
      .in1_mux    (in1_mux),
      .in2_mux    (in2_mux),
      .alu_op     (alu_op),
      .reg_dst    (reg_dst),
      .mem_to_reg (mem_to_reg),
      .reg_write  (reg_write),
      .instr_done (instr_done),
      .state_o    (state_o)
`ifdef MULTICYCLE_TRAP_EN
      ,
      .trap       (trap)
`endif
   );

   always #5 clk = ~clk;

   logic [21:0] obs;
   assign obs = {state_o, mem_req, mem_we, ir_write, pc_write, pc_src, in1_mux, in2_mux,
                 alu_op, reg_dst, mem_to_reg, reg_write, instr_done};

   function automatic logic [21:0] v(input int st, input int req, input int we, input int irw,
                                     input int pcw, input int pcs, input int i1, input int i2,
                                     input int aop, input int rd, input int m2r, input int rw,
                                     input int dn);
      return {st[2:0], req[0], we[0], irw[0], pcw[0], pcs[1:0], i1[1:0], i2[0],
              aop[3:0], rd[1:0], m2r[1:0], rw[0], dn[0]};
   endfunction

   task automatic chk(input string tag, input logic [21:0] o, input logic [21:0] e);
      n_cmp++;
      assert (o === e) else begin
         n_bad++;
         $error("FAIL %s observed=%h expected=%h", tag, o, e);
      end
   endtask

   task automatic cyc(input string tag, input int op, input int fn, input int z, input int rdy,
                      input logic [21:0] e);
      opcode    = op[5:0];
      func      = fn[5:0];
      zero      = z[0];
      mem_ready = rdy[0];
      @(negedge clk);
      chk(tag, obs, e);
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [21:0] f_ok, f_wait, idle;
      f_ok   = v(0,1,0,1,1,0,0,0,0,0,0,0,0);
      f_wait = v(0,1,0,0,0,0,0,0,0,0,0,0,0);
      idle   = v(1,0,0,0,0,0,0,0,0,0,0,0,0);

      rst_n = 1'b0; opcode = '0; func = '0; zero = 1'b0; mem_ready = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset_state", obs, v(0,0,0,0,0,0,0,0,0,0,0,0,0));
`ifdef MULTICYCLE_TRAP_EN
      chk("reset_trap", {21'b0, trap}, 22'd0);
`endif
      rst_n = 1'b1;
      @(posedge clk); #1;

      cyc("add_fetch", 'h00, 'h20, 0, 1, f_ok);
      cyc("add_dec",   'h00, 'h20, 0, 1, idle);
      cyc("add_exec",  'h00, 'h20, 0, 1, v(2,0,0,0,0,0,0,0,6,0,0,0,0));
      cyc("add_wb",    'h00, 'h20, 0, 1, v(4,0,0,0,0,0,0,0,0,1,0,1,1));

      cyc("lw_fetch", 'h23, 0, 0, 1, f_ok);
      cyc("lw_dec",   'h23, 0, 0, 1, idle);
      cyc("lw_exec",  'h23, 0, 0, 1, v(2,0,0,0,0,0,1,0,6,0,0,0,0));
      for (int i = 0; i < 3; i++)
         cyc("lw_mem_wait", 'h23, 0, 0, 0, v(3,1,0,0,0,0,1,0,6,0,0,0,0));
      cyc("lw_mem_done", 'h23, 0, 0, 1, v(3,1,0,0,0,0,1,0,6,0,0,0,0));
      cyc("lw_wb",       'h23, 0, 0, 1, v(4,0,0,0,0,0,0,0,0,0,1,1,1));

      cyc("beq0_fetch_wait", 'h04, 0, 0, 0, f_wait);
      cyc("beq0_fetch",      'h04, 0, 0, 1, f_ok);
      cyc("beq0_dec",        'h04, 0, 0, 1, idle);
      cyc("beq0_exec",       'h04, 0, 0, 1, v(2,0,0,0,0,1,0,0,7,0,0,0,1));
      cyc("beq1_fetch",      'h04, 0, 1, 1, f_ok);
      cyc("beq1_dec",        'h04, 0, 1, 1, idle);
      cyc("beq1_exec",       'h04, 0, 1, 1, v(2,0,0,0,1,1,0,0,7,0,0,0,1));
      cyc("bne0_fetch",      'h05, 0, 0, 1, f_ok);
      cyc("bne0_dec",        'h05, 0, 0, 1, idle);
      cyc("bne0_exec",       'h05, 0, 0, 1, v(2,0,0,0,1,1,0,0,7,0,0,0,1));

      cyc("jal_fetch", 'h03, 0, 0, 1, f_ok);
      cyc("jal_dec",   'h03, 0, 0, 1, v(1,0,0,0,1,2,0,0,0,0,0,0,0));
      cyc("jal_wb",    'h03, 0, 0, 1, v(4,0,0,0,0,0,0,0,0,2,2,1,1));
      cyc("j_fetch",   'h02, 0, 0, 1, f_ok);
      cyc("j_dec",     'h02, 0, 0, 1, v(1,0,0,0,1,2,0,0,0,0,0,0,1));
      cyc("jr_fetch",  'h00, 'h08, 0, 1, f_ok);
      cyc("jr_dec",    'h00, 'h08, 0, 1, v(1,0,0,0,1,3,0,0,0,0,0,0,1));

      cyc("ori_fetch", 'h0D, 0, 0, 1, f_ok);
      cyc("ori_dec",   'h0D, 0, 0, 1, idle);
      cyc("ori_exec",  'h0D, 0, 0, 1, v(2,0,0,0,0,0,2,0,9,0,0,0,0));
      cyc("ori_wb",    'h0D, 0, 0, 1, v(4,0,0,0,0,0,0,0,0,0,0,1,1));
      cyc("sll_fetch", 'h00, 'h00, 0, 1, f_ok);
      cyc("sll_dec",   'h00, 'h00, 0, 1, idle);
      cyc("sll_exec",  'h00, 'h00, 0, 1, v(2,0,0,0,0,0,0,1,0,0,0,0,0));
      cyc("sll_wb",    'h00, 'h00, 0, 1, v(4,0,0,0,0,0,0,0,0,1,0,1,1));
      cyc("slt_fetch", 'h00, 'h2A, 0, 1, f_ok);
      cyc("slt_dec",   'h00, 'h2A, 0, 1, idle);
      cyc("slt_exec",  'h00, 'h2A, 0, 1, v(2,0,0,0,0,0,0,0,12,0,0,0,0));
      cyc("slt_wb",    'h00, 'h2A, 0, 1, v(4,0,0,0,0,0,0,0,0,1,0,1,1));
      cyc("lui_fetch", 'h0F, 0, 0, 1, f_ok);
      cyc("lui_dec",   'h0F, 0, 0, 1, idle);
      cyc("lui_exec",  'h0F, 0, 0, 1, v(2,0,0,0,0,0,2,0,14,0,0,0,0));
      cyc("lui_wb",    'h0F, 0, 0, 1, v(4,0,0,0,0,0,0,0,0,0,0,1,1));

      cyc("sw_fetch", 'h2B, 0, 0, 1, f_ok);
      cyc("sw_dec",   'h2B, 0, 0, 1, idle);
      cyc("sw_exec",  'h2B, 0, 0, 1, v(2,0,0,0,0,0,1,0,6,0,0,0,0));
      cyc("sw_mem",   'h2B, 0, 0, 1, v(3,1,1,0,0,0,1,0,6,0,0,0,1));

`ifndef MULTICYCLE_TRAP_EN
      cyc("nop_fetch", 'h3F, 0, 0, 1, f_ok);
      cyc("nop_dec",   'h3F, 0, 0, 1, idle);
      cyc("nop_exec",  'h3F, 0, 0, 1, v(2,0,0,0,0,0,0,0,0,0,0,0,1));
`endif

      cyc("rsw_fetch",    'h2B, 0, 0, 1, f_ok);
      cyc("rsw_dec",      'h2B, 0, 0, 1, idle);
      cyc("rsw_exec",     'h2B, 0, 0, 1, v(2,0,0,0,0,0,1,0,6,0,0,0,0));
      cyc("rsw_mem_wait", 'h2B, 0, 0, 0, v(3,1,1,0,0,0,1,0,6,0,0,0,0));
      #2 rst_n = 1'b0;
      #1 chk("rst_mid_mem", obs, v(0,0,0,0,0,0,0,0,0,0,0,0,0));
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      cyc("post_rst_fetch", 'h2B, 0, 0, 0, f_wait);

`ifdef MULTICYCLE_TRAP_EN
      cyc("ill_fetch", 'h3F, 0, 0, 1, f_ok);
      cyc("ill_dec",   'h3F, 0, 0, 1, idle);
      @(negedge clk);
      chk("ill_trap_state", obs, v(5,0,0,0,0,0,0,0,0,0,0,0,0));
      chk("ill_trap_flag", {21'b0, trap}, 22'd1);
      @(posedge clk); #1;
      chk("ill_trap_held", obs, v(5,0,0,0,0,0,0,0,0,0,0,0,0));

      mem_ready = 1'b0;
      rst_n = 1'b0;
      #1 chk("trap_cleared", {21'b0, trap}, 22'd0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      for (int i = 0; i < 15; i++)
         cyc("to_fetch_wait", 'h00, 'h20, 0, 0, f_wait);
      @(negedge clk);
      chk("to_trap_state", obs, v(5,0,0,0,0,0,0,0,0,0,0,0,0));
      chk("to_trap_flag", {21'b0, trap}, 22'd1);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
